// File: rtl/alu_exec_pkg.sv
// Shared encodings for the EX-stage ALU: ALUOp/funct constants, internal op codes,
// FSM states and the decode function that maps ALUOp/funct to an operation.
package alu_exec_pkg;

    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_ADD   = 3'b001;
    localparam logic [2:0] ALUOP_SLT   = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_SUB   = 3'b100;

    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_DIVU  = 6'd27;
    localparam logic [5:0] FUNCT_ADD   = 6'd32;
    localparam logic [5:0] FUNCT_SUB   = 6'd34;
    localparam logic [5:0] FUNCT_AND   = 6'd36;
    localparam logic [5:0] FUNCT_OR    = 6'd37;
    localparam logic [5:0] FUNCT_SLT   = 6'd42;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
        OP_MFHI, OP_MFLO, OP_MULTU, OP_DIVU, OP_ERR
    } op_e;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

    function automatic op_e decode_op(input logic [2:0] aluop, input logic [5:0] funct);
        op_e op;
        op = OP_ERR;
        case (aluop)
            ALUOP_SUB: op = OP_SUB;
            ALUOP_SLT: op = OP_SLT;
            ALUOP_ADD: op = OP_ADD;
            ALUOP_OR:  op = OP_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:   op = OP_ADD;
                    FUNCT_SUB:   op = OP_SUB;
                    FUNCT_AND:   op = OP_AND;
                    FUNCT_OR:    op = OP_OR;
                    FUNCT_SLT:   op = OP_SLT;
                    FUNCT_MFHI:  op = OP_MFHI;
                    FUNCT_MFLO:  op = OP_MFLO;
                    FUNCT_MULTU: op = OP_MULTU;
                    FUNCT_DIVU:  op = OP_DIVU;
                    default:     op = OP_ERR;
                endcase
            end
            default: op = OP_ERR;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_exec_unit_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// done and the final hi/lo are combinational so the parent can register them on the last edge.
module iter_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start,
    input  logic              is_div,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic              dz,
    output logic [DATA_W-1:0] hi_res,
    output logic [DATA_W-1:0] lo_res
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic              busy_r, div_r;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] hi_r, lo_r, b_r;
    logic [DATA_W-1:0] hi_step, lo_step, div_diff;
    logic [DATA_W:0]   mul_sum, div_shift;
    logic              div_ge, last, dz_short;

    assign dz_short  = start & is_div & (op_b == '0);
    assign last      = busy_r & (cnt == CNT_W'(DATA_W - 1));
    assign mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);
    assign div_shift = {hi_r, lo_r[DATA_W-1]};
    assign div_ge    = div_shift >= {1'b0, b_r};
    assign div_diff  = div_shift[DATA_W-1:0] - b_r;

    // hi_r is the product high half / partial remainder; lo_r shifts multiplier out, quotient in
    always_comb begin
        hi_step = mul_sum[DATA_W:1];
        lo_step = {mul_sum[0], lo_r[DATA_W-1:1]};
        if (div_r) begin
            hi_step = div_ge ? div_diff : div_shift[DATA_W-1:0];
            lo_step = {lo_r[DATA_W-2:0], div_ge};
        end
    end

    assign busy   = busy_r;
    assign done   = last | dz_short;
    assign dz     = dz_short;
    assign hi_res = dz_short ? op_a : hi_step;
    assign lo_res = dz_short ? '1 : lo_step;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_r <= 1'b0;
            div_r  <= 1'b0;
            cnt    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            b_r    <= '0;
        end else if (start && !dz_short) begin
            busy_r <= 1'b1;
            div_r  <= is_div;
            cnt    <= '0;
            hi_r   <= '0;
            lo_r   <= op_a;
            b_r    <= op_b;
        end else if (busy_r) begin
            hi_r <= hi_step;
            lo_r <= lo_step;
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
                busy_r <= 1'b0;
                cnt    <= '0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUOp/funct, runs single-cycle ops directly and MULTU/DIVU
// through iter_muldiv, and owns HI/LO plus the registered result/flag outputs.
//   state | meaning
//   IDLE  | ready for a request; single-cycle ops and divide-by-zero complete here
//   MUL   | iterative multiply in progress, ready_o low
//   DIV   | iterative divide in progress, ready_o low
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        aluop_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              err_o,
    output logic              dz_o
);
    state_e            state, state_next;
    op_e               op;
    logic              accept, start;
    logic              md_busy, md_done, md_dz;
    logic [DATA_W-1:0] md_hi, md_lo, hi_r, lo_r, sc_result;

    assign op      = decode_op(aluop_i, funct_i);
    assign ready_o = (state == IDLE) & ~md_busy;
    assign accept  = valid_i & ready_o;
    assign start   = accept & ((op == OP_MULTU) | (op == OP_DIVU));

    iter_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start  (start),
        .is_div (op == OP_DIVU),
        .op_a   (src1_i),
        .op_b   (src2_i),
        .busy   (md_busy),
        .done   (md_done),
        .dz     (md_dz),
        .hi_res (md_hi),
        .lo_res (md_lo)
    );

    always_comb begin
        sc_result = '0;
        case (op)
            OP_ADD:  sc_result = src1_i + src2_i;
            OP_SUB:  sc_result = src1_i - src2_i;
            OP_AND:  sc_result = src1_i & src2_i;
            OP_OR:   sc_result = src1_i | src2_i;
            OP_SLT:  sc_result = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_MFHI: sc_result = hi_r;
            OP_MFLO: sc_result = lo_r;
            default: sc_result = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !md_dz) state_next = (op == OP_DIVU) ? DIV : MUL;
            MUL,
            DIV:     if (md_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_next;
    end

    // Flags default low every cycle so they are only ever seen alongside valid_o
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o  <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b0;
            err_o    <= 1'b0;
            dz_o     <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            valid_o <= 1'b0;
            zero_o  <= 1'b0;
            err_o   <= 1'b0;
            dz_o    <= 1'b0;
            if (md_done) begin
                valid_o  <= 1'b1;
                result_o <= md_lo;
                zero_o   <= (md_lo == '0);
                dz_o     <= md_dz;
                hi_r     <= md_hi;
                lo_r     <= md_lo;
            end else if (accept && !start) begin
                valid_o  <= 1'b1;
                result_o <= sc_result;
                zero_o   <= (sc_result == '0);
                err_o    <= (op == OP_ERR);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit at DATA_W=32 and DATA_W=8 with hand-computed expectations.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  aluop = '0;
    logic [5:0]  funct = '0;

    logic        valid_i = 1'b0, ready_o, valid_o, zero_o, err_o, dz_o;
    logic [31:0] src1 = '0, src2 = '0, result_o;

    logic        v8_i = 1'b0, r8_o, v8_o, z8_o, e8_o, d8_o;
    logic [7:0]  a8 = '0, b8 = '0, res8_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    always #5 clk = ~clk;

    alu_exec_unit #(.DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .aluop_i(aluop), .funct_i(funct), .src1_i(src1), .src2_i(src2),
        .valid_o(valid_o), .result_o(result_o), .zero_o(zero_o), .err_o(err_o), .dz_o(dz_o)
    );

    alu_exec_unit #(.DATA_W(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(v8_i), .ready_o(r8_o),
        .aluop_i(aluop), .funct_i(funct), .src1_i(a8), .src2_i(b8),
        .valid_o(v8_o), .result_o(res8_o), .zero_o(z8_o), .err_o(e8_o), .dz_o(d8_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        aluop = op; funct = fn; src1 = a; src2 = b; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic issue8(input logic [2:0] op, input logic [5:0] fn, input logic [7:0] a, input logic [7:0] b);
        aluop = op; funct = fn; a8 = a; b8 = b; v8_i = 1'b1;
        @(posedge clk); #1;
        v8_i = 1'b0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready_o && cnt < 200) begin @(posedge clk); #1; cnt++; end
    endtask

    task automatic wait_ready8(output int cnt);
        cnt = 0;
        while (!r8_o && cnt < 200) begin @(posedge clk); #1; cnt++; end
    endtask

    task automatic check_sc(input string tag, input logic [31:0] exp);
        chk({tag, "_valid"}, valid_o, 1'b1);
        chk({tag, "_result"}, result_o, exp);
        chk({tag, "_err"}, err_o, 1'b0);
    endtask

    initial begin
        #12;
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_result", result_o, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // R-type sweep with 7 and -3
        issue(3'b000, 6'd32, 32'd7, 32'hFFFF_FFFD); check_sc("add", 32'd4);
        issue(3'b000, 6'd34, 32'd7, 32'hFFFF_FFFD); check_sc("sub", 32'd10);
        issue(3'b000, 6'd36, 32'd7, 32'hFFFF_FFFD); check_sc("and", 32'd5);
        issue(3'b000, 6'd37, 32'd7, 32'hFFFF_FFFD); check_sc("or", 32'hFFFF_FFFF);
        issue(3'b000, 6'd42, 32'd7, 32'hFFFF_FFFD); check_sc("slt", 32'd0);
        chk("slt_zero", zero_o, 1'b1);
        @(posedge clk); #1;
        chk("pulse_one_cycle", valid_o, 1'b0);
        issue(3'b000, 6'd42, 32'hFFFF_FFFD, 32'd7); check_sc("slt_neg", 32'd1);
        issue(3'b000, 6'd34, 32'd9, 32'd9); check_sc("sub_eq", 32'd0);
        chk("sub_eq_zero", zero_o, 1'b1);
        issue(3'b100, 6'd0, 32'd20, 32'd25); check_sc("aluop_sub", 32'hFFFF_FFFB);
        chk("aluop_sub_zero", zero_o, 1'b0);
        issue(3'b010, 6'd0, 32'd3, 32'd4); check_sc("aluop_slt", 32'd1);
        issue(3'b001, 6'hFF & 6'd5, 32'hFFFF_FFFF, 32'd2); check_sc("aluop_add_wrap", 32'd1);
        issue(3'b011, 6'd0, 32'hF0, 32'h0F); check_sc("aluop_or", 32'hFF);

        // MULTU max*max
        issue(3'b000, 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_ready(n);
        chk("multu_busy_cycles", n, 32);
        chk("multu_valid", valid_o, 1'b1);
        chk("multu_result", result_o, 32'h1);
        issue(3'b000, 6'd16, 32'd0, 32'd0); check_sc("multu_mfhi", 32'hFFFF_FFFE);
        issue(3'b000, 6'd18, 32'd0, 32'd0); check_sc("multu_mflo", 32'h1);

        // Errors leave HI/LO alone
        issue(3'b000, 6'h3F, 32'd1, 32'd1);
        chk("err_funct_valid", valid_o, 1'b1);
        chk("err_funct_err", err_o, 1'b1);
        chk("err_funct_result", result_o, 32'h0);
        issue(3'b111, 6'd32, 32'd1, 32'd1);
        chk("err_aluop_err", err_o, 1'b1);
        chk("err_aluop_result", result_o, 32'h0);
        issue(3'b000, 6'd16, 32'd0, 32'd0); check_sc("err_hi_kept", 32'hFFFF_FFFE);
        issue(3'b000, 6'd18, 32'd0, 32'd0); check_sc("err_lo_kept", 32'h1);

        // DIVU
        issue(3'b000, 6'd27, 32'd100, 32'd7);
        wait_ready(n);
        chk("divu_busy_cycles", n, 32);
        chk("divu_valid", valid_o, 1'b1);
        chk("divu_result", result_o, 32'd14);
        chk("divu_dz", dz_o, 1'b0);
        issue(3'b000, 6'd16, 32'd0, 32'd0); check_sc("divu_mfhi", 32'd2);
        issue(3'b000, 6'd27, 32'd5, 32'd0);
        chk("dz_valid", valid_o, 1'b1);
        chk("dz_flag", dz_o, 1'b1);
        chk("dz_result", result_o, 32'hFFFF_FFFF);
        chk("dz_ready", ready_o, 1'b1);
        issue(3'b000, 6'd16, 32'd0, 32'd0); check_sc("dz_mfhi", 32'd5);
        chk("dz_flag_clear", dz_o, 1'b0);

        // Request held during DIV executes exactly once after it
        aluop = 3'b000; funct = 6'd27; src1 = 32'd50; src2 = 32'd5; valid_i = 1'b1;
        @(posedge clk); #1;
        aluop = 3'b001; funct = 6'd0; src1 = 32'd1; src2 = 32'd2;
        n = 0;
        while (!valid_o && n < 200) begin @(posedge clk); #1; n++; end
        chk("hold_div_latency", n, 32);
        chk("hold_div_result", result_o, 32'd10);
        chk("hold_ready", ready_o, 1'b1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        check_sc("hold_add", 32'd3);
        @(posedge clk); #1;
        chk("hold_once", valid_o, 1'b0);

        // Back-to-back: ADD issued in the MULTU valid cycle
        issue(3'b000, 6'd25, 32'h0001_0000, 32'h0003_0000);
        wait_ready(n);
        chk("b2b_mul_cycles", n, 32);
        chk("b2b_mul_valid", valid_o, 1'b1);
        chk("b2b_mul_result", result_o, 32'h0);
        chk("b2b_mul_zero", zero_o, 1'b1);
        issue(3'b000, 6'd32, 32'd20, 32'd22); check_sc("b2b_add", 32'd42);

        // Reset in the middle of a MULTU (HI currently 3)
        issue(3'b000, 6'd25, 32'hFFFF_FFFF, 32'h1234_5678);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_ready", ready_o, 1'b1);
        chk("midrst_valid", valid_o, 1'b0);
        chk("midrst_result", result_o, 32'h0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        issue(3'b000, 6'd16, 32'd0, 32'd0); check_sc("midrst_mfhi", 32'd0);

        // DATA_W = 8
        issue8(3'b000, 6'd25, 8'hFF, 8'hFF);
        wait_ready8(n);
        chk("w8_mul_cycles", n, 8);
        chk("w8_mul_valid", v8_o, 1'b1);
        chk("w8_mul_result", res8_o, 8'h01);
        issue8(3'b000, 6'd16, 8'd0, 8'd0);
        chk("w8_mfhi", res8_o, 8'hFE);
        issue8(3'b000, 6'd27, 8'd200, 8'd7);
        wait_ready8(n);
        chk("w8_div_result", res8_o, 8'd28);
        issue8(3'b000, 6'd16, 8'd0, 8'd0);
        chk("w8_div_rem", res8_o, 8'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
